// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table, pi constants, gain-compensation factor
// and the vectoring FSM state type.
package cordic_pkg;

  localparam int Q16_FRAC   = 16;
  localparam int ATAN_DEPTH = 14;

  // atan(2**-i) in Q16, i = 0..13; requantised to the z format where used.
  localparam logic signed [31:0] ATAN_Q16 [ATAN_DEPTH] = '{
    32'sd51472, 32'sd30386, 32'sd16055, 32'sd8150, 32'sd4091, 32'sd2047, 32'sd1024,
    32'sd512,   32'sd256,   32'sd128,   32'sd64,   32'sd32,   32'sd16,   32'sd8
  };

  localparam logic signed [31:0] PI_Q16      = 32'sd205887;
  localparam logic signed [31:0] PI_HALF_Q16 = 32'sd102944;

  // 1/K for the CORDIC gain, applied as (x * K_INV) >>> K_INV_SHIFT.
  localparam logic [7:0] K_INV       = 8'd155;
  localparam int         K_INV_SHIFT = 8;

  typedef enum logic [1:0] {IDLE, ITER, SCALE, DONE} cordic_vec_state_t;

  // Requantise a Q16 constant to 'frac' fractional bits, rounding half-up.
  function automatic logic signed [31:0] to_frac(input logic signed [31:0] q16, input int frac);
    logic signed [31:0] res;
    if (frac >= Q16_FRAC) res = q16 <<< (frac - Q16_FRAC);
    else                  res = (q16 + (32'sd1 <<< (Q16_FRAC - frac - 1))) >>> (Q16_FRAC - frac);
    return res;
  endfunction

  function automatic logic signed [31:0] atan_z(input logic [3:0] idx, input int frac);
    logic signed [31:0] res;
    res = '0;
    if (int'(idx) < ATAN_DEPTH) res = to_frac(ATAN_Q16[idx], frac);
    return res;
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One vectoring-mode CORDIC micro-rotation (combinational): rotates (x,y) towards the
// +x axis by atan(2**-shift) and accumulates the rotated angle in z.
module cordic_vec_stage #(
  parameter int XW = 14,
  parameter int ZW = 13
) (
  input  logic signed [XW-1:0] x,
  input  logic signed [XW-1:0] y,
  input  logic signed [ZW-1:0] z,
  input  logic        [3:0]    shift,
  input  logic signed [ZW-1:0] atan,
  output logic signed [XW-1:0] x_next,
  output logic signed [XW-1:0] y_next,
  output logic signed [ZW-1:0] z_next
);

  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;

  assign x_sh = x >>> shift;
  assign y_sh = y >>> shift;

  always_comb begin
    if (y[XW-1]) begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - atan;
    end else begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + atan;
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x,y) -> atan2(y,x) and magnitude, one micro-rotation
// per clock. Define CORDIC_GAIN_COMP_EN to add a SCALE step that removes the CORDIC gain.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ITERATIONS = 8,
  parameter int GUARD      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic signed [DATA_WIDTH-1:0] y_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [DATA_WIDTH:0]   angle_out,
  output logic signed [DATA_WIDTH-1:0] mag_out
);

  localparam int XW = DATA_WIDTH + 2 + GUARD;
  localparam int ZW = DATA_WIDTH + 1 + GUARD;
  localparam int ZF = DATA_WIDTH - 2 + GUARD;
  localparam int AW = DATA_WIDTH + 1;
  localparam int XR = XW + 1;
  localparam int ZR = ZW + 1;
  localparam int PW = XW + 9;

  localparam logic [3:0]           LAST_ITER = 4'(ITERATIONS - 1);
  localparam logic signed [ZW-1:0] PI_HALF_Z = ZW'(to_frac(PI_HALF_Q16, ZF));
  localparam logic signed [ZR-1:0] Z_HALF    = ZR'(2 ** (GUARD - 1));
  localparam logic signed [XR-1:0] X_HALF    = XR'(2 ** GUARD);
  localparam logic signed [XR-1:0] MAG_MAX_X = XR'(2 ** (DATA_WIDTH - 1) - 1);

`ifdef CORDIC_GAIN_COMP_EN
  localparam cordic_vec_state_t AFTER_ITER = SCALE;
`else
  localparam cordic_vec_state_t AFTER_ITER = DONE;
`endif

  cordic_vec_state_t state;
  cordic_vec_state_t state_next;

  logic signed [XW-1:0] x_q, y_q, x_next, y_next, x_ext, y_ext, x_pre, y_pre, x_scaled;
  logic signed [ZW-1:0] z_q, z_next, z_pre, atan_cur;
  logic        [3:0]    iter_cnt;
  logic                 zero_q;
  logic                 accept;

  logic signed [ZR-1:0]         z_round;
  logic signed [XR-1:0]         x_round;
  logic signed [AW-1:0]         angle_rnd;
  logic signed [DATA_WIDTH-1:0] mag_sat;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign x_ext    = XW'(x_in) <<< GUARD;
  assign y_ext    = XW'(y_in) <<< GUARD;
  assign atan_cur = ZW'(atan_z(iter_cnt, ZF));

  // Fold left-half-plane inputs into the right half so the iterations converge.
  always_comb begin
    x_pre = x_ext;
    y_pre = y_ext;
    z_pre = '0;
    if (x_in[DATA_WIDTH-1]) begin
      if (!y_in[DATA_WIDTH-1]) begin
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = PI_HALF_Z;
      end else begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = -PI_HALF_Z;
      end
    end
  end

  cordic_vec_stage #(
    .XW(XW),
    .ZW(ZW)
  ) u_stage (
    .x     (x_q),
    .y     (y_q),
    .z     (z_q),
    .shift (iter_cnt),
    .atan  (atan_cur),
    .x_next(x_next),
    .y_next(y_next),
    .z_next(z_next)
  );

`ifdef CORDIC_GAIN_COMP_EN
  logic signed [PW-1:0] x_prod;
  assign x_prod   = PW'(x_q) * PW'($signed({1'b0, K_INV}));
  assign x_scaled = XW'(x_prod >>> K_INV_SHIFT);
`else
  assign x_scaled = x_q;
`endif

  // Half-up rounding to the output formats; magnitude clamps to [0, max positive].
  always_comb begin
    z_round   = (ZR'(z_q) + Z_HALF) >>> GUARD;
    x_round   = (XR'(x_q) + X_HALF) >>> (GUARD + 1);
    angle_rnd = zero_q ? '0 : AW'(z_round);
    if (zero_q || x_round[XR-1]) mag_sat = '0;
    else if (x_round > MAG_MAX_X) mag_sat = DATA_WIDTH'(MAG_MAX_X);
    else mag_sat = DATA_WIDTH'(x_round);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = ITER;
      ITER:    if (iter_cnt == LAST_ITER) state_next = AFTER_ITER;
      SCALE:   state_next = DONE;
      DONE:    if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      iter_cnt  <= '0;
      zero_q    <= 1'b0;
      out_valid <= 1'b0;
      angle_out <= '0;
      mag_out   <= '0;
    end else begin
      // NOTE: non-blocking so every register updates from its pre-edge value.
      case (state)
        IDLE: if (accept) begin
          x_q      <= x_pre;
          y_q      <= y_pre;
          z_q      <= z_pre;
          iter_cnt <= '0;
          zero_q   <= (x_in == '0) && (y_in == '0);
        end
        ITER: begin
          x_q      <= x_next;
          y_q      <= y_next;
          z_q      <= z_next;
          iter_cnt <= iter_cnt + 4'd1;
        end
        SCALE: x_q <= x_scaled;
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            angle_out <= angle_rnd;
            mag_out   <= mag_sat;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
